// File: rtl/handshake_seq_checker.sv
// handshake_seq_checker
// Receiving end of a valid/ready handshake test stream. It drives ready_o
// with a selectable backpressure pattern and checks that the accepted data
// increments by one on every transfer. It reports transfer, cycle and error
// counts, the first mismatch seen, and a done flag once TARGET_CNT
// transfers have been accepted.
module handshake_seq_checker #(
  parameter int          DATA_W     = 8,
  parameter int          START_VAL  = 1,
  parameter int          TARGET_CNT = 200,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [1:0]        stall_mode,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic [15:0]       xfer_cnt,
  output logic [15:0]       err_cnt,
  output logic [15:0]       cycle_cnt,
  output logic              err_flag,
  output logic [DATA_W-1:0] first_err_data,
  output logic [DATA_W-1:0] first_err_exp,
  output logic              done
);

  localparam logic [DATA_W-1:0] START  = DATA_W'(START_VAL);
  localparam logic [15:0]       TARGET = 16'(TARGET_CNT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_ready;
  logic [15:0]       r_xfer_cnt;
  logic [15:0]       r_err_cnt;
  logic [15:0]       r_cycle_cnt;
  logic              r_err_flag;
  logic [DATA_W-1:0] r_first_data;
  logic [DATA_W-1:0] r_first_exp;
  logic              r_done;
  logic [DATA_W-1:0] r_exp;
  logic [15:0]       r_lfsr;

  logic              w_in_run;
  logic              w_xfer;
  logic              w_mismatch;
  logic [15:0]       w_xfer_nxt;
  logic              w_last;
  logic              w_exit;
  logic              w_lfsr_fb;
  logic              w_ready_nxt;

  // Ready is gated with RUN so nothing is accepted in IDLE/DONE even if
  // the ready register were somehow high there.
  assign w_in_run   = (r_state == S_RUN);
  assign w_xfer     = w_in_run && valid_i && r_ready;
  assign w_mismatch = w_xfer && (data_i != r_exp);
  assign w_xfer_nxt = r_xfer_cnt + 16'd1;
  assign w_last     = w_xfer && (w_xfer_nxt == TARGET);
  // Any edge that leaves RUN: abort or the final transfer.
  assign w_exit     = w_in_run && (!enable || w_last);
  // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10.
  assign w_lfsr_fb  = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  // Next ready value: backpressure pattern while staying in RUN, else 0.
  always_comb begin
    w_ready_nxt = 1'b0;
    if (w_in_run && !w_exit) begin
      case (stall_mode)
        2'b00:   w_ready_nxt = 1'b1;
        2'b01:   w_ready_nxt = ~r_lfsr[0];
        2'b10:   w_ready_nxt = ~r_ready;
        default: w_ready_nxt = 1'b0;
      endcase
    end
  end

  // Registered ready to the upstream bridge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ready <= 1'b0;
    else        r_ready <= w_ready_nxt;
  end

  // Stall LFSR; runs only in RUN and keeps its state across runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_lfsr <= LFSR_SEED;
    else if (w_in_run) r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
  end

  // Run-control FSM with sequence checking and the reported counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_xfer_cnt   <= '0;
      r_err_cnt    <= '0;
      r_cycle_cnt  <= '0;
      r_err_flag   <= 1'b0;
      r_first_data <= '0;
      r_first_exp  <= '0;
      r_done       <= 1'b0;
      r_exp        <= START;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_state      <= S_RUN;
            r_xfer_cnt   <= '0;
            r_err_cnt    <= '0;
            r_cycle_cnt  <= '0;
            r_err_flag   <= 1'b0;
            r_first_data <= '0;
            r_first_exp  <= '0;
            r_exp        <= START;
          end
        end
        S_RUN: begin
          if (r_cycle_cnt != 16'hFFFF) r_cycle_cnt <= r_cycle_cnt + 16'd1;
          if (w_xfer) begin
            r_xfer_cnt <= w_xfer_nxt;
            // Expected always advances; no resync to received data.
            r_exp      <= r_exp + DATA_W'(1);
            if (w_mismatch) begin
              if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
              r_err_flag <= 1'b1;
              if (!r_err_flag) begin
                r_first_data <= data_i;
                r_first_exp  <= r_exp;
              end
            end
          end
          // Abort wins over completion on the same edge.
          if (!enable) begin
            r_state <= S_IDLE;
          end else if (w_last) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          if (!enable) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o        = r_ready;
  assign xfer_cnt       = r_xfer_cnt;
  assign err_cnt        = r_err_cnt;
  assign cycle_cnt      = r_cycle_cnt;
  assign err_flag       = r_err_flag;
  assign first_err_data = r_first_data;
  assign first_err_exp  = r_first_exp;
  assign done           = r_done;

endmodule

// File: tb/tb_handshake_seq_checker.sv
// Bench for handshake_seq_checker: the bench acts as the incrementing-data
// sender, predicts counts per transfer into a scoreboard queue and compares
// them one cycle later. A second instance covers the data wrap-around.
module tb_handshake_seq_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  stall_mode = 2'b00;
  logic        valid_i = 1'b0;
  logic [7:0]  data_i = 8'd0;
  logic        ready_o;
  logic [15:0] xfer_cnt, err_cnt, cycle_cnt;
  logic        err_flag, done;
  logic [7:0]  first_err_data, first_err_exp;

  logic        w_en = 1'b0;
  logic        w_vld = 1'b0;
  logic [7:0]  w_dat = 8'd0;
  logic        w_rdy;
  logic [15:0] w_xfer, w_err, w_cyc;
  logic        w_flag, w_done;
  logic [7:0]  w_fed, w_fex;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [15:0] xfer;
    logic [15:0] err;
  } sb_t;
  sb_t sbq[$];

  logic [7:0]  m_exp;
  logic [15:0] m_xfer, m_err;

  handshake_seq_checker u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .stall_mode(stall_mode),
    .valid_i(valid_i), .data_i(data_i), .ready_o(ready_o),
    .xfer_cnt(xfer_cnt), .err_cnt(err_cnt), .cycle_cnt(cycle_cnt),
    .err_flag(err_flag), .first_err_data(first_err_data),
    .first_err_exp(first_err_exp), .done(done)
  );

  handshake_seq_checker #(.START_VAL(250), .TARGET_CNT(10)) u_wrap (
    .clk(clk), .rst_n(rst_n), .enable(w_en), .stall_mode(2'b00),
    .valid_i(w_vld), .data_i(w_dat), .ready_o(w_rdy),
    .xfer_cnt(w_xfer), .err_cnt(w_err), .cycle_cnt(w_cyc),
    .err_flag(w_flag), .first_err_data(w_fed),
    .first_err_exp(w_fex), .done(w_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_start();
    m_exp  = 8'd1;
    m_xfer = 16'd0;
    m_err  = 16'd0;
    sbq.delete();
  endtask

  // One clock: predict a transfer, push expected counts, compare after edge.
  task automatic step(output bit x);
    sb_t e;
    x = valid_i && ready_o;
    if (x) begin
      if (data_i !== m_exp) m_err = m_err + 16'd1;
      m_xfer = m_xfer + 16'd1;
      m_exp  = m_exp + 8'd1;
      e.xfer = m_xfer;
      e.err  = m_err;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    if (x) begin
      e = sbq.pop_front();
      total++;
      if (xfer_cnt !== e.xfer || err_cnt !== e.err) begin
        bad++;
        $display("FAIL sb_counts: xfer_cnt=%0d err_cnt=%0d expected %0d/%0d",
                 xfer_cnt, err_cnt, e.xfer, e.err);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    total++;
    if (ready_o !== 1'b0 || done !== 1'b0 || err_flag !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: ready=%b done=%b flag=%b expected 0/0/0", ready_o, done, err_flag);
    end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (xfer_cnt !== 16'd0 || err_cnt !== 16'd0 || cycle_cnt !== 16'd0 ||
        first_err_data !== 8'd0 || first_err_exp !== 8'd0) begin
      bad++;
      $display("FAIL reset_counts: xfer=%0d err=%0d cyc=%0d fd=%0d fe=%0d expected all 0",
               xfer_cnt, err_cnt, cycle_cnt, first_err_data, first_err_exp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    bit x;
    model_start();
    stall_mode = 2'b00;
    valid_i = 1'b1;
    data_i = 8'd1;
    enable = 1'b1;
    step(x);
    total++;
    if (ready_o !== 1'b0) begin
      bad++;
      $display("FAIL stream_entry_ready: ready=%b expected 0", ready_o);
    end
    for (int c = 0; c < 400 && m_xfer < 16'd200; c++) begin
      step(x);
      if (x) data_i = data_i + 8'd1;
    end
    total++;
    if (xfer_cnt !== 16'd200 || err_cnt !== 16'd0 || err_flag !== 1'b0 || done !== 1'b1) begin
      bad++;
      $display("FAIL stream_final: xfer=%0d err=%0d flag=%b done=%b expected 200/0/0/1",
               xfer_cnt, err_cnt, err_flag, done);
    end
    total++;
    if (cycle_cnt !== 16'd201 || ready_o !== 1'b0) begin
      bad++;
      $display("FAIL stream_cycles: cyc=%0d ready=%b expected 201/0", cycle_cnt, ready_o);
    end
    repeat (3) step(x);
    total++;
    if (xfer_cnt !== 16'd200 || done !== 1'b1 || cycle_cnt !== 16'd201) begin
      bad++;
      $display("FAIL stream_hold_done: xfer=%0d done=%b cyc=%0d expected 200/1/201",
               xfer_cnt, done, cycle_cnt);
    end
    enable = 1'b0;
    valid_i = 1'b0;
    step(x);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL stream_done_clear: done=%b expected 0", done);
    end
  endtask

  task automatic test_stall_always();
    bit x;
    int rdy_hi;
    model_start();
    rdy_hi = 0;
    stall_mode = 2'b11;
    valid_i = 1'b1;
    data_i = 8'd1;
    enable = 1'b1;
    step(x);
    for (int c = 0; c < 50; c++) begin
      step(x);
      if (ready_o !== 1'b0) rdy_hi++;
    end
    total++;
    if (rdy_hi != 0) begin
      bad++;
      $display("FAIL stall_ready: ready high on %0d cycles expected 0", rdy_hi);
    end
    total++;
    if (xfer_cnt !== 16'd0 || cycle_cnt !== 16'd50) begin
      bad++;
      $display("FAIL stall_counts: xfer=%0d cyc=%0d expected 0/50", xfer_cnt, cycle_cnt);
    end
    enable = 1'b0;
    valid_i = 1'b0;
    step(x);
  endtask

  task automatic test_mismatch();
    bit x;
    logic [7:0] tbl [7];
    int i;
    tbl = '{8'd1, 8'd2, 8'd3, 8'd9, 8'd5, 8'd6, 8'd8};
    model_start();
    stall_mode = 2'b00;
    i = 0;
    data_i = tbl[0];
    valid_i = 1'b1;
    enable = 1'b1;
    for (int c = 0; c < 40 && i < 7; c++) begin
      step(x);
      if (x) begin
        i++;
        if (i < 7) data_i = tbl[i];
        if (i == 6) begin
          total++;
          if (err_cnt !== 16'd1 || first_err_data !== 8'd9 || first_err_exp !== 8'd4) begin
            bad++;
            $display("FAIL mis_first: err=%0d fd=%0d fe=%0d expected 1/9/4",
                     err_cnt, first_err_data, first_err_exp);
          end
        end
      end
    end
    // Abort with a transfer on the same edge: it is still counted.
    data_i = 8'd8;
    enable = 1'b0;
    step(x);
    total++;
    if (x !== 1'b1 || ready_o !== 1'b0 || xfer_cnt !== 16'd8) begin
      bad++;
      $display("FAIL mis_abort_xfer: taken=%b ready=%b xfer=%0d expected 1/0/8", x, ready_o, xfer_cnt);
    end
    total++;
    if (err_cnt !== 16'd2 || err_flag !== 1'b1 || first_err_data !== 8'd9 || first_err_exp !== 8'd4) begin
      bad++;
      $display("FAIL mis_sticky: err=%0d flag=%b fd=%0d fe=%0d expected 2/1/9/4",
               err_cnt, err_flag, first_err_data, first_err_exp);
    end
    valid_i = 1'b0;
  endtask

  task automatic test_wrap();
    bit x;
    int n;
    n = 0;
    w_dat = 8'd250;
    w_vld = 1'b1;
    w_en  = 1'b1;
    for (int c = 0; c < 60 && n < 10; c++) begin
      x = w_vld && w_rdy;
      @(posedge clk); #1;
      if (x) begin
        n++;
        w_dat = w_dat + 8'd1;
      end
    end
    total++;
    if (w_xfer !== 16'd10 || w_err !== 16'd0 || w_flag !== 1'b0 || w_done !== 1'b1) begin
      bad++;
      $display("FAIL wrap_final: xfer=%0d err=%0d flag=%b done=%b expected 10/0/0/1",
               w_xfer, w_err, w_flag, w_done);
    end
    total++;
    if (w_cyc !== 16'd11 || w_rdy !== 1'b0) begin
      bad++;
      $display("FAIL wrap_cycles: cyc=%0d ready=%b expected 11/0", w_cyc, w_rdy);
    end
    w_en  = 1'b0;
    w_vld = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_lfsr_abort();
    bit x;
    logic [15:0] m_lfsr;
    logic nr;
    int rdy_bad;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    m_lfsr = 16'hACE1;
    rdy_bad = 0;
    model_start();
    stall_mode = 2'b01;
    valid_i = 1'b0;
    data_i = 8'd1;
    enable = 1'b1;
    step(x);
    for (int c = 0; c < 2000 && m_xfer < 16'd50; c++) begin
      valid_i = 1'($urandom_range(0, 1));
      nr = ~m_lfsr[0];
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      step(x);
      if (x) data_i = data_i + 8'd1;
      if (ready_o !== nr) rdy_bad++;
    end
    total++;
    if (rdy_bad != 0) begin
      bad++;
      $display("FAIL lfsr_ready: ready differed from pattern on %0d cycles expected 0", rdy_bad);
    end
    enable = 1'b0;
    valid_i = 1'b0;
    step(x);
    total++;
    if (ready_o !== 1'b0 || xfer_cnt !== 16'd50) begin
      bad++;
      $display("FAIL abort_hold: ready=%b xfer=%0d expected 0/50", ready_o, xfer_cnt);
    end
    repeat (3) step(x);
    total++;
    if (xfer_cnt !== 16'd50 || err_cnt !== 16'd0) begin
      bad++;
      $display("FAIL abort_readout: xfer=%0d err=%0d expected 50/0", xfer_cnt, err_cnt);
    end
    // Re-run: counters clear and expected restarts at 1.
    model_start();
    stall_mode = 2'b00;
    enable = 1'b1;
    step(x);
    total++;
    if (xfer_cnt !== 16'd0 || cycle_cnt !== 16'd0) begin
      bad++;
      $display("FAIL rerun_clear: xfer=%0d cyc=%0d expected 0/0", xfer_cnt, cycle_cnt);
    end
    data_i = 8'd1;
    valid_i = 1'b1;
    for (int c = 0; c < 20 && m_xfer < 16'd5; c++) begin
      step(x);
      if (x) data_i = data_i + 8'd1;
    end
    total++;
    if (xfer_cnt !== 16'd5 || err_cnt !== 16'd0 || err_flag !== 1'b0) begin
      bad++;
      $display("FAIL rerun_restart: xfer=%0d err=%0d flag=%b expected 5/0/0", xfer_cnt, err_cnt, err_flag);
    end
    enable = 1'b0;
    valid_i = 1'b0;
    step(x);
  endtask

  task automatic test_reset_midrun();
    bit x;
    logic er;
    int rdy_bad;
    rdy_bad = 0;
    model_start();
    stall_mode = 2'b10;
    valid_i = 1'b1;
    data_i = 8'd1;
    enable = 1'b1;
    step(x);
    er = 1'b0;
    for (int c = 0; c < 10; c++) begin
      er = ~er;
      step(x);
      if (x) data_i = data_i + 8'd1;
      if (ready_o !== er) rdy_bad++;
    end
    total++;
    if (rdy_bad != 0 || xfer_cnt !== 16'd5) begin
      bad++;
      $display("FAIL alt_ready: mispatterned=%0d xfer=%0d expected 0/5", rdy_bad, xfer_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (ready_o !== 1'b0 || done !== 1'b0 || xfer_cnt !== 16'd0 ||
        err_cnt !== 16'd0 || cycle_cnt !== 16'd0 || err_flag !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: ready=%b done=%b xfer=%0d err=%0d cyc=%0d flag=%b expected all 0",
               ready_o, done, xfer_cnt, err_cnt, cycle_cnt, err_flag);
    end
    enable = 1'b0;
    valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (ready_o !== 1'b0 || cycle_cnt !== 16'd0) begin
      bad++;
      $display("FAIL idle_after_reset: ready=%b cyc=%0d expected 0/0", ready_o, cycle_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_always();
    test_mismatch();
    test_wrap();
    test_lfsr_abort();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/handshake_seq_checker.md
# handshake_seq_checker

Synthesizable sink for the valid/ready handshake test streams. It terminates the post-stage side of a handshake bridge under test and drives `ready_o` with a programmable backpressure pattern. It checks that accepted data forms an incrementing sequence and reports transfer, cycle and error counts plus a done flag. It is the receiving counterpart of the incrementing-data sender and replaces the behavioural reference-data checker, so bridge tests can run on hardware.

## Interface
Parameters:
- `DATA_W`, 8, data width.
- `START_VAL`, 1, first expected data value.
- `TARGET_CNT`, 200, number of accepted transfers before done; range 1..65535.
- `LFSR_SEED`, 16'hACE1, stall LFSR reset value; must be nonzero.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `enable`  in  1  start/abort a check run.
- `stall_mode`  in  2  backpressure pattern: 00 none, 01 LFSR random, 10 alternate, 11 always stall.
- `valid_i`  in  1  data valid from the upstream bridge.
- `data_i`  in  DATA_W  data from the upstream bridge.
- `ready_o`  out  1  registered ready to the upstream bridge.
- `xfer_cnt`  out  16  accepted transfers in the current run.
- `err_cnt`  out  16  data mismatches, saturating at 16'hFFFF.
- `cycle_cnt`  out  16  cycles spent in RUN, saturating.
- `err_flag`  out  1  sticky; set when a run has seen at least one mismatch.
- `first_err_data`  out  DATA_W  `data_i` value at the first mismatch.
- `first_err_exp`  out  DATA_W  expected value at the first mismatch.
- `done`  out  1  high in DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN when `enable`=1. On this transition the block clears `xfer_cnt`, `err_cnt`, `cycle_cnt`, `err_flag` and both `first_err_*` outputs, and loads the expected register with `START_VAL`. The LFSR is not reseeded.
- RUN → DONE on the accepted transfer that makes `xfer_cnt` equal `TARGET_CNT`.
- RUN → IDLE when `enable`=0, checked before the done test. Counters hold their values for readout.
- DONE → IDLE when `enable`=0. DONE holds while `enable`=1.
- Transfer occurs when `valid_i && ready_o` at a rising edge. Only transfers are counted and checked.
- Check: if `data_i` ≠ expected, increment `err_cnt` (saturating) and set `err_flag`. When `err_flag` was previously 0, also capture `first_err_data`/`first_err_exp`.
- Expected advances by +1 mod 2^DATA_W on every transfer, match or not (255→0 at DATA_W=8). There is no resync to received data.
- `ready_o` is independent of `valid_i`. Ready may drop while valid is low or high.
- Next `ready_o` is 0 outside RUN or on the RUN exit edge. In RUN it follows `stall_mode`:
  - 00: 1.
  - 01: ~LFSR[0].
  - 10: ~`ready_o` (toggles).
  - 11: 0.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; shift in XOR of bits 15,13,12,10. It advances every cycle in RUN and holds otherwise.
- `cycle_cnt` increments every cycle in RUN, saturating at 16'hFFFF.

## Timing
- Reset values:
  - `ready_o`=0, `done`=0, `err_flag`=0.
  - all counts 0, `first_err_*`=0.
  - expected=`START_VAL`, LFSR=`LFSR_SEED`, state IDLE.
- Reset is asynchronous, so all of the above take effect immediately, including mid-run. A transfer in flight at reset is discarded uncounted.
- `enable` rising edge: RUN from the next edge. The first `ready_o`=1 can appear 1 cycle after entering RUN (mode 00).
- All outputs are registered. Counts reflect a transfer one cycle after its edge.
- Final transfer edge: `done`=1 and `ready_o`=0 on the same following cycle. No transfer is accepted after the TARGET_CNT-th.
- A `stall_mode` change affects the next `ready_o` computation (1-cycle latency).
- `enable` drop in RUN: `ready_o`=0 from the next cycle. A transfer on that same edge is still counted and checked.

## Test plan
- Mode 00 with the sender streaming 1..200 continuously: `xfer_cnt`=200, `err_cnt`=0, `err_flag`=0, `done`=1. `cycle_cnt` equals 201: 1 cycle entering RUN before ready rises, plus 200 transfer cycles.
- Mode 11 with `valid_i` held 1 for 50 cycles: `ready_o` stays 0, `xfer_cnt`=0, `cycle_cnt`=50.
- Data stream 1,2,3,9,5,6 in mode 00: `err_cnt`=1, `first_err_data`=9, `first_err_exp`=4, and 5 and 6 are accepted clean.
- `START_VAL`=250, `TARGET_CNT`=10, data 250..255,0..3: `err_cnt`=0, `done`=1, wrap handled correctly.
- Mode 01 with random valid, then `enable` dropped after 50 transfers:
  - `ready_o`=0 the next cycle and `xfer_cnt` holds 50.
  - Re-raising `enable` clears `xfer_cnt` to 0 and restarts expected at `START_VAL`.
- Mode 10 with `rst_n` asserted mid-run: `ready_o`, `done` and all counts go to 0 without a clock edge. After release, the block stays in IDLE until `enable` is seen.
